atri_daughter_readout_sched: RTL and testbench
==============================================

# atri_daughter_readout_sched

Parametrised readout scheduler for the ATRI board family that generalises the single-daughter readout path to 1–4 daughterboards. On each event readout request it services every present and enabled daughter stack in ascending index order, one at a time, through a grant/start/done handshake with the per-daughter IRS readout engines. It sits between the event trigger/buffer logic and the per-daughter readout engines inside the board top-level. It reports completion, overrun and, optionally, per-daughter watchdog timeouts.

## Interface
- NUM_DAUGHTERS, default 4: number of daughter slots, legal 1..4.
- TIMEOUT_CYCLES, default 65535: watchdog limit in clk_i cycles, legal 1..65535. Used only with the watchdog macro.

- clk_i  in  1  sole clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- present_i  in  NUM_DAUGHTERS  daughter-present sense, one bit per slot; quasi-static.
- enable_i  in  NUM_DAUGHTERS  software readout enable per slot.
- req_i  in  1  readout request, one-cycle pulse per event.
- done_i  in  NUM_DAUGHTERS  per-daughter readout-complete pulse.
- clr_timeout_i  in  1  clears timeout_o.
- grant_o  out  NUM_DAUGHTERS  one-hot; high while a daughter is being serviced.
- start_o  out  NUM_DAUGHTERS  one-cycle start pulse to the granted daughter.
- cur_idx_o  out  2  index of the current or last granted daughter.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle pulse when all selected daughters are finished.
- empty_o  out  1  one-cycle pulse, coincident with done_o, when the latched mask was zero.
- overrun_o  out  1  one-cycle pulse when req_i arrives while busy.
- timeout_o  out  NUM_DAUGHTERS  sticky per-daughter timeout flags.

## Operation
- States: IDLE, SCAN, WAIT.
- **IDLE**
  - When req_i=1, latch mask = present_i & enable_i (upper bits zero when NUM_DAUGHTERS<4).
  - Go to SCAN.
- **SCAN**
  - If mask≠0, select k = lowest set bit.
  - Register grant_o = 1<<k, start_o = 1<<k, cur_idx_o = k.
  - Clear the watchdog counter and go to WAIT.
  - If mask=0, pulse done_o and go to IDLE. empty_o also pulses if no daughter was granted during this request.
- **WAIT**
  - start_o is high only in the first WAIT cycle.
  - done_i[k] is accepted only when start_o is low. On acceptance: clear grant_o, clear mask[k], go to SCAN.
  - done_i bits other than k are ignored. done_i[k] during the start_o cycle is ignored.
- **req_i while busy_o=1:** request is dropped and overrun_o pulses. No queueing.
- **present_i / enable_i changes mid-request:** no effect until the next request, because the mask is latched.
- **rst_i:** synchronous, overrides everything, including mid-WAIT. State returns to IDLE and mask is cleared.
- **Output values under reset:** grant_o=0, start_o=0, cur_idx_o=0, busy_o=0, done_o=0, empty_o=0, overrun_o=0, timeout_o=0.
- **clr_timeout_i:** clears all timeout_o bits. If a timeout sets in the same cycle, set wins.

## Timing
- All outputs are registered. Cycle n is the cycle in which req_i is sampled high.
  - n+1: busy_o=1, state SCAN.
  - n+2: grant_o and start_o high for the first daughter.
- Each daughter costs 1 SCAN cycle, plus 1 start cycle, plus the cycles until done_i.
- With done_i returned in the earliest legal cycle, each daughter takes 3 cycles.
  - 4 daughters present: done_o is high at cycle n+14.
  - Mask = 0: done_o and empty_o are high at cycle n+2, and busy_o=0 from n+3.
- The next req_i is accepted in the cycle after done_o, when busy_o=0.

## Configuration
- Macro: ATRI_READOUT_WATCHDOG_EN.
- **Defined:**
  - A 16-bit counter runs in WAIT. It is cleared on entry to WAIT.
  - When the count reaches TIMEOUT_CYCLES without done_i[k]: set timeout_o[k], clear grant_o and mask[k], go to SCAN.
  - done_i[k] in the same cycle as expiry counts as completion; no timeout is flagged.
- **Undefined:** no counter, timeout_o is tied to 0, WAIT lasts indefinitely, and TIMEOUT_CYCLES is ignored.

## Test plan
- **Basic ordering, full population:** NUM_DAUGHTERS=4, present=enable=4'b1111, req pulse, done_i returned 1 cycle after each start.
  - start_o sequence 0001, 0010, 0100, 1000.
  - done_o at n+14, then busy_o=0.
- **Sparse mask:** present=4'b1010, enable=4'b1111.
  - Only slots 1 and 3 are granted.
  - cur_idx_o reads 1 then 3.
  - done_o at n+8.
- **Empty mask:** enable=0, req.
  - done_o and empty_o pulse together at n+2.
  - No start_o.
- **Overrun:** req, then a second req while in WAIT.
  - overrun_o pulses once.
  - Only one done_o.
  - Ignored-input cases in the same run:
    - done_i on a non-granted slot has no effect.
    - done_i during the start cycle has no effect.
- **Reset mid-operation:** assert rst_i during WAIT for daughter 2.
  - Next cycle: all outputs 0 and state IDLE.
  - A following req restarts from slot 0.
- **Watchdog (macro defined):** TIMEOUT_CYCLES=10, slot 1 never returns done_i.
  - grant_o[1] drops after 10 WAIT cycles and timeout_o=4'b0010.
  - Slot 2 is then serviced.
  - clr_timeout_i clears the flag.

Source files
------------

// File: rtl/atri_daughter_readout_sched.sv
// atri_daughter_readout_sched
// Services every present & enabled daughter stack in ascending index order,
// one at a time, via a grant/start/done handshake with the per-daughter IRS
// readout engines. Reports completion, empty requests and overruns.
// Optional per-daughter watchdog: define ATRI_READOUT_WATCHDOG_EN.
module atri_daughter_readout_sched #(
   parameter int NUM_DAUGHTERS  = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_DAUGHTERS-1:0] present_i,
   input  logic [NUM_DAUGHTERS-1:0] enable_i,
   input  logic                     req_i,
   input  logic [NUM_DAUGHTERS-1:0] done_i,
   input  logic                     clr_timeout_i,
   output logic [NUM_DAUGHTERS-1:0] grant_o,
   output logic [NUM_DAUGHTERS-1:0] start_o,
   output logic [1:0]               cur_idx_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     empty_o,
   output logic                     overrun_o,
   output logic [NUM_DAUGHTERS-1:0] timeout_o
);

   localparam int N = NUM_DAUGHTERS;

   typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

   state_t         state, state_nx;
   logic [N-1:0]   mask, mask_nx;
   logic           empty_req, empty_req_nx;
   logic [N-1:0]   grant_nx, start_nx, lowbit;
   logic [1:0]     idx_nx, sel_idx;
   logic           busy_nx, done_nx, empty_nx, overrun_nx;
   logic           accept, expire;

   // Lowest set bit of the remaining mask: one-hot form and index
   always_comb begin
      sel_idx = '0;
      lowbit  = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (mask[i]) begin
            sel_idx   = 2'(i);
            lowbit    = '0;
            lowbit[i] = 1'b1;
         end
      end
   end

   // grant_o is one-hot, so the granted daughter's done is picked out by AND;
   // a done coinciding with the start pulse is ignored.
   assign accept = (state == WAIT) && !(|start_o) && (|(done_i & grant_o));

`ifdef ATRI_READOUT_WATCHDOG_EN
   logic [15:0] wd_cnt;

   // Watchdog counts WAIT cycles; zero outside WAIT so each grant starts fresh
   always_ff @(posedge clk_i) begin
      if (rst_i || state != WAIT) wd_cnt <= '0;
      else                        wd_cnt <= wd_cnt + 16'd1;
   end

   // Expiry in the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle done wins
   assign expire = (state == WAIT) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) && !accept;

   // Sticky timeout flags; a new timeout beats a simultaneous clear
   always_ff @(posedge clk_i) begin
      if (rst_i) timeout_o <= '0;
      else       timeout_o <= (clr_timeout_i ? '0 : timeout_o) | (expire ? grant_o : '0);
   end
`else
   logic unused_wd;
   assign unused_wd = clr_timeout_i;
   assign expire    = 1'b0;
   assign timeout_o = '0;
`endif

   // Next-state and registered-output values
   always_comb begin
      state_nx     = state;
      mask_nx      = mask;
      empty_req_nx = empty_req;
      grant_nx     = grant_o;
      start_nx     = '0;
      idx_nx       = cur_idx_o;
      done_nx      = 1'b0;
      empty_nx     = 1'b0;
      // busy_o also covers the done_o cycle, so a request there is an overrun
      overrun_nx   = req_i & busy_o;
      case (state)
         IDLE: begin
            if (req_i && !busy_o) begin
               mask_nx      = present_i & enable_i;
               empty_req_nx = ~|(present_i & enable_i);
               state_nx     = SCAN;
            end
         end
         SCAN: begin
            if (|mask) begin
               grant_nx = lowbit;
               start_nx = lowbit;
               idx_nx   = sel_idx;
               state_nx = WAIT;
            end else begin
               done_nx  = 1'b1;
               empty_nx = empty_req;
               state_nx = IDLE;
            end
         end
         WAIT: begin
            if (accept || expire) begin
               grant_nx = '0;
               mask_nx  = mask & ~grant_o;
               state_nx = SCAN;
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE) | done_nx;
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         mask      <= '0;
         empty_req <= 1'b0;
         grant_o   <= '0;
         start_o   <= '0;
         cur_idx_o <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         empty_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         state     <= state_nx;
         mask      <= mask_nx;
         empty_req <= empty_req_nx;
         grant_o   <= grant_nx;
         start_o   <= start_nx;
         cur_idx_o <= idx_nx;
         busy_o    <= busy_nx;
         done_o    <= done_nx;
         empty_o   <= empty_nx;
         overrun_o <= overrun_nx;
      end
   end

endmodule

// File: tb/tb_atri_daughter_readout_sched.sv
// Bench for atri_daughter_readout_sched: per-request expected timelines are
// built from the scheduling rules (scan/start/done cycle arithmetic) and
// compared cycle by cycle against the DUT.
module tb_atri_daughter_readout_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pres, en, done_in, grant, start, tmo;
   logic       req, clr;
   logic [1:0] idx;
   logic       busy, done_o, empty, ovr;

   int total = 0;
   int bad   = 0;
   logic [1:0] last_idx = 2'd0;

   atri_daughter_readout_sched #(.NUM_DAUGHTERS(4), .TIMEOUT_CYCLES(10)) dut (
      .clk_i(clk), .rst_i(rst), .present_i(pres), .enable_i(en), .req_i(req),
      .done_i(done_in), .clr_timeout_i(clr), .grant_o(grant), .start_o(start),
      .cur_idx_o(idx), .busy_o(busy), .done_o(done_o), .empty_o(empty),
      .overrun_o(ovr), .timeout_o(tmo)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   // One request: ovr_mode 0 none, 1 single extra req in WAIT, 2 random extras
   task automatic run_req(input logic [3:0] p, input logic [3:0] e, input int dmax,
                          input bit noise, input int ovr_mode,
                          output int dcyc, output int n_done, output int n_ovr);
      logic [3:0] eg[64], es[64], din[64];
      logic [1:0] ei[64];
      logic       ed[64], ee[64], eb[64], eo[64];
      bit         rq[64];
      logic [3:0] m;
      int t, d, len;
      m = p & e;
      for (int c = 0; c < 64; c++) begin
         eg[c] = '0; es[c] = '0; din[c] = '0; ei[c] = last_idx;
         ed[c] = 1'b0; ee[c] = 1'b0; eb[c] = 1'b0; eo[c] = 1'b0; rq[c] = 1'b0;
      end
      t = 1;
      for (int k = 0; k < 4; k++) begin
         if (m[k]) begin
            d = $urandom_range(dmax, 1);
            for (int c = t+1; c <= t+1+d; c++) eg[c][k] = 1'b1;
            es[t+1][k] = 1'b1;
            for (int c = t+1; c < 64; c++) ei[c] = 2'(k);
            din[t+1+d][k] = 1'b1;
            last_idx = 2'(k);
            t = t + 2 + d;
         end
      end
      ed[t+1] = 1'b1;
      ee[t+1] = (m == 4'b0);
      for (int c = 1; c <= t+1; c++) eb[c] = 1'b1;
      len = t + 2;
      if (noise)
         for (int c = 0; c <= len; c++)
            for (int j = 0; j < 4; j++)
               if (!eg[c][j] || es[c][j]) din[c][j] = din[c][j] | ($urandom_range(3, 0) == 0);
      rq[0] = 1'b1;
      if (ovr_mode == 1) rq[2] = 1'b1;
      if (ovr_mode == 2) for (int c = 1; c <= t+1; c++) rq[c] = ($urandom_range(4, 0) == 0);
      for (int c = 1; c <= t+1; c++) eo[c+1] = rq[c];
      dcyc = -1; n_done = 0; n_ovr = 0;
      for (int c = 0; c <= len; c++) begin
         @(posedge clk); #1;
         total++;
         if ({grant, start, idx, busy, done_o, empty, ovr, tmo} !==
             {eg[c], es[c], ei[c], eb[c], ed[c], ee[c], eo[c], 4'b0}) begin
            bad++;
            $display("FAIL cycle_check c=%0d got g=%b s=%b i=%0d b=%b d=%b e=%b o=%b t=%b want g=%b s=%b i=%0d b=%b d=%b e=%b o=%b t=0000",
                     c, grant, start, idx, busy, done_o, empty, ovr, tmo,
                     eg[c], es[c], ei[c], eb[c], ed[c], ee[c], eo[c]);
         end
         if (done_o === 1'b1) begin
            n_done++;
            if (dcyc < 0) dcyc = c;
         end
         if (ovr === 1'b1) n_ovr++;
         req     = rq[c];
         done_in = din[c];
         if (c == 0) begin
            pres = p; en = e;
         end else if (noise) begin
            pres = 4'($urandom); en = 4'($urandom);
         end
      end
      req = 1'b0; done_in = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; clr = 1'b0; done_in = '0; pres = '0; en = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({grant, start, idx, busy, done_o, empty, ovr, tmo} !== 21'b0) begin
         bad++;
         $display("FAIL reset_outputs got g=%b s=%b i=%0d b=%b d=%b e=%b o=%b t=%b want all zero",
                  grant, start, idx, busy, done_o, empty, ovr, tmo);
      end
      rst = 1'b0;
      last_idx = 2'd0;
   endtask

   task automatic test_full();
      int dc, nd, no;
      run_req(4'hF, 4'hF, 1, 1'b0, 0, dc, nd, no);
      total++;
      if (dc !== 14) begin
         bad++; $display("FAIL full_done_cycle got %0d want 14", dc);
      end
   endtask

   task automatic test_sparse();
      int dc, nd, no;
      run_req(4'b1010, 4'hF, 1, 1'b0, 0, dc, nd, no);
      total++;
      if (dc !== 8) begin
         bad++; $display("FAIL sparse_done_cycle got %0d want 8", dc);
      end
   endtask

   task automatic test_empty();
      int dc, nd, no;
      run_req(4'hF, 4'h0, 1, 1'b0, 0, dc, nd, no);
      total++;
      if (dc !== 2) begin
         bad++; $display("FAIL empty_done_cycle got %0d want 2", dc);
      end
   endtask

   task automatic test_overrun();
      int dc, nd, no;
      run_req(4'hF, 4'hF, 3, 1'b1, 1, dc, nd, no);
      total++;
      if (no !== 1 || nd !== 1) begin
         bad++; $display("FAIL overrun_counts got ovr=%0d done=%0d want ovr=1 done=1", no, nd);
      end
   endtask

   task automatic test_reset_mid();
      int dc, nd, no;
      pres = 4'hF; en = 4'hF;
      for (int c = 0; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 9) begin
            total++;
            if (grant !== 4'b0100 || idx !== 2'd2 || busy !== 1'b1) begin
               bad++; $display("FAIL mid_wait_slot2 got g=%b i=%0d b=%b want g=0100 i=2 b=1", grant, idx, busy);
            end
         end
         if (c == 10) begin
            total++;
            if ({grant, start, idx, busy, done_o, empty, ovr, tmo} !== 21'b0) begin
               bad++;
               $display("FAIL reset_mid_outputs got g=%b s=%b i=%0d b=%b d=%b e=%b o=%b t=%b want all zero",
                        grant, start, idx, busy, done_o, empty, ovr, tmo);
            end
         end
         req     = (c == 0);
         done_in = (c == 3) ? 4'b0001 : (c == 6) ? 4'b0010 : 4'b0000;
         rst     = (c == 9);
      end
      rst = 1'b0; req = 1'b0; done_in = '0;
      last_idx = 2'd0;
      run_req(4'hF, 4'hF, 1, 1'b0, 0, dc, nd, no);
      total++;
      if (dc !== 14) begin
         bad++; $display("FAIL restart_done_cycle got %0d want 14", dc);
      end
   endtask

   task automatic test_random();
      int dc, nd, no;
      for (int i = 0; i < 30; i++)
         run_req(4'($urandom), 4'($urandom), $urandom_range(6, 1), 1'b1, 2, dc, nd, no);
   endtask

`ifdef ATRI_READOUT_WATCHDOG_EN
   task automatic test_watchdog();
      pres = 4'b0110; en = 4'b0110;
      for (int c = 0; c <= 18; c++) begin
         @(posedge clk); #1;
         if (c == 11) begin
            total++;
            if (grant !== 4'b0010 || tmo !== 4'b0) begin
               bad++; $display("FAIL wd_before got g=%b t=%b want g=0010 t=0000", grant, tmo);
            end
         end
         if (c == 12) begin
            total++;
            if (grant !== 4'b0000 || tmo !== 4'b0010) begin
               bad++; $display("FAIL wd_expire got g=%b t=%b want g=0000 t=0010", grant, tmo);
            end
         end
         if (c == 13) begin
            total++;
            if (start !== 4'b0100 || idx !== 2'd2) begin
               bad++; $display("FAIL wd_next_slot got s=%b i=%0d want s=0100 i=2", start, idx);
            end
         end
         if (c == 16) begin
            total++;
            if (done_o !== 1'b1) begin
               bad++; $display("FAIL wd_done got %b want 1", done_o);
            end
         end
         if (c == 18) begin
            total++;
            if (tmo !== 4'b0) begin
               bad++; $display("FAIL wd_clear got t=%b want 0000", tmo);
            end
         end
         req     = (c == 0);
         done_in = (c == 14) ? 4'b0100 : 4'b0000;
         clr     = (c == 17);
      end
      req = 1'b0; done_in = '0; clr = 1'b0;
      last_idx = 2'd2;
   endtask
`endif

   initial begin
      test_reset();
      test_full();
      test_sparse();
      test_empty();
      test_overrun();
      test_reset_mid();
`ifdef ATRI_READOUT_WATCHDOG_EN
      test_watchdog();
`endif
      test_random();
      test_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
